// File: rtl/coin_credit_acc_if.sv
// Front-end bus between the coin mechanism / vending core and the credit accumulator.
interface coin_credit_acc_if;
  logic [3:0] coin_in;
  logic       vend_req;
  logic [7:0] vend_price;
  logic       refund_req;
  logic [7:0] money;
  logic       vend_ack;
  logic       vend_nak;
  logic       coin_reject;
  logic [3:0] payout;
  logic       busy;

  modport master (
    output coin_in, vend_req, vend_price, refund_req,
    input  money, vend_ack, vend_nak, coin_reject, payout, busy
  );

  modport slave (
    input  coin_in, vend_req, vend_price, refund_req,
    output money, vend_ack, vend_nak, coin_reject, payout, busy
  );
endinterface

// File: rtl/coin_credit_acc.sv
// Coin credit accumulator: saturating credit from coin strobes, vend debit settlement,
// and a paced largest-coin-first refund train.
//
// state  | meaning
// IDLE   | accepting coins and vend debits; waits for refund_req with credit != 0
// PAYOUT | one cycle: emit the largest coin not exceeding credit and debit it
// GAP    | PULSE_GAP idle cycles between coin-out pulses
module coin_credit_acc #(
  parameter int MAX_CREDIT = 200,
  parameter int COIN_V0    = 1,
  parameter int COIN_V1    = 2,
  parameter int COIN_V2    = 5,
  parameter int COIN_V3    = 10,
  parameter int PULSE_GAP  = 4
) (
  input logic              clk,
  input logic              rst_n,
  coin_credit_acc_if.slave bus
);

  localparam logic [7:0] V0    = 8'(COIN_V0);
  localparam logic [7:0] V1    = 8'(COIN_V1);
  localparam logic [7:0] V2    = 8'(COIN_V2);
  localparam logic [7:0] V3    = 8'(COIN_V3);
  localparam logic [8:0] MAX9  = 9'(MAX_CREDIT);
  localparam int         GW    = $clog2(PULSE_GAP + 1);
  localparam logic [GW-1:0] GAP_LOAD = GW'(PULSE_GAP - 1);

  typedef enum logic [1:0] {ST_IDLE, ST_PAYOUT, ST_GAP} state_t;

  state_t        state_q, state_d;
  logic [7:0]    credit_q, credit_d;
  logic [GW-1:0] cnt_q, cnt_d;
  logic          ack_q, ack_d;
  logic          nak_q, nak_d;
  logic          rej_q, rej_d;
  logic [3:0]    pay_q, pay_d;

  logic          coin_one_hot;
  logic [7:0]    coin_val;
  logic [7:0]    debit;
  logic [7:0]    add;

  // Decode a single coin strobe into its value; anything else is not one-hot.
  always_comb begin
    coin_one_hot = 1'b1;
    coin_val     = 8'd0;
    case (bus.coin_in)
      4'b0001: coin_val = V0;
      4'b0010: coin_val = V1;
      4'b0100: coin_val = V2;
      4'b1000: coin_val = V3;
      default: coin_one_hot = 1'b0;
    endcase
  end

  // Next-state, credit arithmetic and registered-output pulses.
  always_comb begin
    state_d  = state_q;
    credit_d = credit_q;
    cnt_d    = cnt_q;
    ack_d    = 1'b0;
    nak_d    = 1'b0;
    rej_d    = 1'b0;
    pay_d    = 4'b0000;
    debit    = 8'd0;
    add      = 8'd0;

    if (state_q != ST_IDLE) begin
      rej_d = |bus.coin_in;
      nak_d = bus.vend_req;
    end

    case (state_q)
      ST_IDLE: begin
        // Vend and coin are both judged against the credit held at the start of the cycle.
        if (bus.vend_req) begin
          if (bus.vend_price <= credit_q) begin
            ack_d = 1'b1;
            debit = bus.vend_price;
          end else begin
            nak_d = 1'b1;
          end
        end
        if (bus.coin_in != 4'b0000) begin
          if (coin_one_hot && (({1'b0, credit_q} + {1'b0, coin_val}) <= MAX9)) begin
            add = coin_val;
          end else begin
            rej_d = 1'b1;
          end
        end
        credit_d = credit_q - debit + add;
        // A refund request coinciding with a vend or coin waits for a later clean cycle.
        if (bus.refund_req && (credit_q != 8'd0) && !bus.vend_req &&
            (bus.coin_in == 4'b0000)) begin
          state_d = ST_PAYOUT;
        end
      end
      ST_PAYOUT: begin
        if (credit_q >= V3) begin
          pay_d    = 4'b1000;
          credit_d = credit_q - V3;
        end else if (credit_q >= V2) begin
          pay_d    = 4'b0100;
          credit_d = credit_q - V2;
        end else if (credit_q >= V1) begin
          pay_d    = 4'b0010;
          credit_d = credit_q - V1;
        end else begin
          pay_d    = 4'b0001;
          credit_d = credit_q - V0;
        end
        cnt_d   = GAP_LOAD;
        state_d = ST_GAP;
      end
      ST_GAP: begin
        if (cnt_q == '0) begin
          state_d = (credit_q != 8'd0) ? ST_PAYOUT : ST_IDLE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State, credit and output registers; reset discards any residual credit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      credit_q <= 8'd0;
      cnt_q    <= '0;
      ack_q    <= 1'b0;
      nak_q    <= 1'b0;
      rej_q    <= 1'b0;
      pay_q    <= 4'b0000;
    end else begin
      state_q  <= state_d;
      credit_q <= credit_d;
      cnt_q    <= cnt_d;
      ack_q    <= ack_d;
      nak_q    <= nak_d;
      rej_q    <= rej_d;
      pay_q    <= pay_d;
    end
  end

  assign bus.money       = credit_q;
  assign bus.vend_ack    = ack_q;
  assign bus.vend_nak    = nak_q;
  assign bus.coin_reject = rej_q;
  assign bus.payout      = pay_q;
  assign bus.busy        = (state_q != ST_IDLE);

endmodule

// File: tb/tb_coin_credit_acc.sv
// Directed bench for coin_credit_acc: coins, saturation, vends, refund train, reset abort.
module tb_coin_credit_acc;

  logic clk;
  logic rst_n;
  int   n_chk;
  int   n_bad;

  coin_credit_acc_if bus_if ();

  coin_credit_acc dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Compare one observed value with its hand-computed expectation.
  task automatic chk(input string tag, input int obs, input int exp);
    n_chk++;
    if (obs != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d want %0d", tag, obs, exp);
    end
  endtask

  // Present inputs for one rising edge, then clear them 1 ns after the edge.
  task automatic step(input logic [3:0] c, input logic v, input logic [7:0] p,
                      input logic r);
    bus_if.coin_in    = c;
    bus_if.vend_req   = v;
    bus_if.vend_price = p;
    bus_if.refund_req = r;
    @(posedge clk);
    #1;
    bus_if.coin_in    = 4'b0000;
    bus_if.vend_req   = 1'b0;
    bus_if.vend_price = 8'd0;
    bus_if.refund_req = 1'b0;
  endtask

  task automatic do_reset();
    bus_if.coin_in    = 4'b0000;
    bus_if.vend_req   = 1'b0;
    bus_if.vend_price = 8'd0;
    bus_if.refund_req = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int exp_pay;
    int exp_money;
    n_chk = 0;
    n_bad = 0;

    // Reset state
    do_reset();
    chk("rst_money", bus_if.money, 0);
    chk("rst_busy", bus_if.busy, 0);
    chk("rst_payout", bus_if.payout, 0);
    chk("rst_reject", bus_if.coin_reject, 0);

    // Coin accumulation
    step(4'b1000, 1'b0, 8'd0, 1'b0);
    chk("coin10_money", bus_if.money, 10);
    chk("coin10_rej", bus_if.coin_reject, 0);
    step(4'b0100, 1'b0, 8'd0, 1'b0);
    chk("coin5_money", bus_if.money, 15);
    step(4'b0010, 1'b0, 8'd0, 1'b0);
    chk("coin2_money", bus_if.money, 17);
    chk("coin2_rej", bus_if.coin_reject, 0);
    step(4'b0011, 1'b0, 8'd0, 1'b0);
    chk("multi_rej", bus_if.coin_reject, 1);
    chk("multi_money", bus_if.money, 17);

    // Saturation at the credit ceiling
    do_reset();
    for (int i = 0; i < 19; i++) step(4'b1000, 1'b0, 8'd0, 1'b0);
    step(4'b0100, 1'b0, 8'd0, 1'b0);
    chk("fill_money", bus_if.money, 195);
    step(4'b1000, 1'b0, 8'd0, 1'b0);
    chk("sat_rej", bus_if.coin_reject, 1);
    chk("sat_money", bus_if.money, 195);
    step(4'b0100, 1'b0, 8'd0, 1'b0);
    chk("max_rej", bus_if.coin_reject, 0);
    chk("max_money", bus_if.money, 200);

    // Vend debits, refused vend, zero price, refund deferred by a same-cycle coin
    do_reset();
    for (int i = 0; i < 3; i++) step(4'b1000, 1'b0, 8'd0, 1'b0);
    step(4'b0000, 1'b1, 8'd35, 1'b0);
    chk("vend35_nak", bus_if.vend_nak, 1);
    chk("vend35_ack", bus_if.vend_ack, 0);
    chk("vend35_money", bus_if.money, 30);
    step(4'b0000, 1'b1, 8'd25, 1'b0);
    chk("vend25_ack", bus_if.vend_ack, 1);
    chk("vend25_money", bus_if.money, 5);
    step(4'b0000, 1'b1, 8'd0, 1'b0);
    chk("vend0_ack", bus_if.vend_ack, 1);
    chk("vend0_money", bus_if.money, 5);
    step(4'b0001, 1'b0, 8'd0, 1'b1);
    chk("refcoin_money", bus_if.money, 6);
    chk("refcoin_busy", bus_if.busy, 0);
    step(4'b0000, 1'b0, 8'd0, 1'b1);
    chk("refheld_busy", bus_if.busy, 1);

    // Refund train of 18 with coin and vend attempts while busy
    do_reset();
    step(4'b0000, 1'b0, 8'd0, 1'b1);
    chk("ref0_busy", bus_if.busy, 0);
    step(4'b1000, 1'b0, 8'd0, 1'b0);
    step(4'b0100, 1'b0, 8'd0, 1'b0);
    step(4'b0010, 1'b0, 8'd0, 1'b0);
    step(4'b0001, 1'b0, 8'd0, 1'b0);
    chk("ref18_money", bus_if.money, 18);
    step(4'b0000, 1'b0, 8'd0, 1'b1);
    chk("ref_start_busy", bus_if.busy, 1);
    chk("ref_start_pay", bus_if.payout, 0);
    for (int k = 1; k <= 21; k++) begin
      step((k == 3) ? 4'b0001 : 4'b0000, (k == 8), 8'd1, 1'b0);
      exp_pay = (k == 1) ? 8 : (k == 6) ? 4 : (k == 11) ? 2 : (k == 16) ? 1 : 0;
      exp_money = (k < 6) ? 8 : (k < 11) ? 3 : (k < 16) ? 1 : 0;
      chk($sformatf("ref_pay_k%0d", k), bus_if.payout, exp_pay);
      chk($sformatf("ref_money_k%0d", k), bus_if.money, exp_money);
      chk($sformatf("ref_busy_k%0d", k), bus_if.busy, (k <= 19) ? 1 : 0);
      chk($sformatf("ref_rej_k%0d", k), bus_if.coin_reject, (k == 3) ? 1 : 0);
      chk($sformatf("ref_nak_k%0d", k), bus_if.vend_nak, (k == 8) ? 1 : 0);
    end

    // Same-cycle vend and coin, then reset in the middle of a refund
    do_reset();
    step(4'b1000, 1'b0, 8'd0, 1'b0);
    step(4'b1000, 1'b0, 8'd0, 1'b0);
    step(4'b0100, 1'b1, 8'd20, 1'b0);
    chk("both_ack", bus_if.vend_ack, 1);
    chk("both_rej", bus_if.coin_reject, 0);
    chk("both_money", bus_if.money, 5);
    step(4'b1000, 1'b0, 8'd0, 1'b0);
    chk("pre_ref_money", bus_if.money, 15);
    step(4'b0000, 1'b0, 8'd0, 1'b1);
    step(4'b0000, 1'b0, 8'd0, 1'b0);
    chk("mid_pay", bus_if.payout, 8);
    chk("mid_money", bus_if.money, 5);
    chk("mid_busy", bus_if.busy, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("abort_money", bus_if.money, 0);
    chk("abort_pay", bus_if.payout, 0);
    chk("abort_busy", bus_if.busy, 0);
    @(negedge clk);
    rst_n = 1'b1;
    step(4'b0000, 1'b0, 8'd0, 1'b0);
    chk("post_money", bus_if.money, 0);
    chk("post_busy", bus_if.busy, 0);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
